// File: rtl/crypt_batch_sched.sv
// Batch scheduler for the 16-slot pipelined crypt engine: gathers candidates,
// aligns launch to the engine lap boundary, and checks each slot's hash at lap end.
//
// state | meaning
// FILL  | accepting candidates into slots
// ARM   | batch full or flushed, waiting for engine counter 24/15
// RUN   | engine lap in progress, slots frozen
// DRAIN | engine outputs final, one slot compared per cycle
module crypt_batch_sched #(
    parameter int NUM_SLOTS  = 16,
    parameter int LAST_SUPER = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] salt_in,
    input  logic [87:0] target_in,
    input  logic        cand_valid,
    input  logic [63:0] cand_pass,
    output logic        cand_ready,
    input  logic        flush,
    input  logic [4:0]  eng_super_round,
    input  logic [3:0]  eng_des_round,
    input  logic [87:0] eng_out,
    output logic [63:0] eng_pass,
    output logic [15:0] eng_salt,
    output logic        hit_valid,
    output logic [63:0] hit_pass,
    output logic [3:0]  hit_slot,
    output logic        batch_done,
    output logic [4:0]  batch_hits,
    output logic        busy
);

    localparam logic [4:0] LAST_S = 5'(LAST_SUPER);

    typedef enum logic [1:0] {FILL, ARM, RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [63:0]          slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid;
    logic [4:0]           count;
    logic [4:0]           hit_cnt;
    logic [87:0]          target_q;

    logic       accept;
    logic [4:0] count_inc;
    logic       at_lap_end;
    logic       at_drain_end;
    logic       slot_match;
    logic       drain_exit;

    assign at_lap_end   = (eng_super_round == LAST_S) && (eng_des_round == 4'hf);
    assign at_drain_end = (eng_super_round == 5'd0) && (eng_des_round == 4'hf);
    assign accept       = cand_valid && cand_ready;
    assign count_inc    = count + 5'(accept);
    assign slot_match   = (state == DRAIN) && valid[eng_des_round] && (eng_out == target_q);
    assign drain_exit   = (state == DRAIN) && at_drain_end;

    assign eng_pass = valid[eng_des_round] ? slot[eng_des_round] : 64'd0;
    assign busy     = (state != FILL);

    always_comb begin
        state_nxt  = state;
        cand_ready = 1'b0;
        case (state)
            FILL: begin
                // Gated by rst_n so the source never sees ready while held in reset.
                cand_ready = rst_n && (count < 5'd16);
                if (count_inc == 5'd16 || (flush && count_inc != 5'd0))
                    state_nxt = ARM;
            end
            ARM:   if (at_lap_end) state_nxt = RUN;
            RUN:   if (at_lap_end) state_nxt = DRAIN;
            DRAIN: if (at_drain_end) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
            valid <= '0;
        end else if (drain_exit) begin
            count <= 5'd0;
            valid <= '0;
        end else if (accept) begin
            valid[count[3:0]] <= 1'b1;
            count             <= count_inc;
        end
    end

    // Slot contents need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (accept) slot[count[3:0]] <= cand_pass;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_salt <= 16'd0;
            target_q <= 88'd0;
        end else if (state == ARM && at_lap_end) begin
            eng_salt <= salt_in;
            target_q <= target_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid  <= 1'b0;
            hit_pass   <= 64'd0;
            hit_slot   <= 4'd0;
            hit_cnt    <= 5'd0;
            batch_done <= 1'b0;
            batch_hits <= 5'd0;
        end else begin
            hit_valid  <= slot_match;
            batch_done <= drain_exit;
            if (slot_match) begin
                hit_pass <= slot[eng_des_round];
                hit_slot <= eng_des_round;
            end
            if (drain_exit) begin
                batch_hits <= hit_cnt + 5'(slot_match);
                hit_cnt    <= 5'd0;
            end else if (slot_match) begin
                hit_cnt <= hit_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_crypt_batch_sched.sv
// Scoreboard bench for crypt_batch_sched with a toy engine model standing in
// for the crypt pipeline (hash = simple keyed mix of key and salt).
module tb_crypt_batch_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] salt_in;
    logic [87:0] target_in;
    logic        cand_valid;
    logic [63:0] cand_pass;
    logic        cand_ready;
    logic        flush;
    logic [4:0]  eng_super_round;
    logic [3:0]  eng_des_round;
    logic [87:0] eng_out;
    logic [63:0] eng_pass;
    logic [15:0] eng_salt;
    logic        hit_valid;
    logic [63:0] hit_pass;
    logic [3:0]  hit_slot;
    logic        batch_done;
    logic [4:0]  batch_hits;
    logic        busy;

    crypt_batch_sched dut (
        .clk(clk), .rst_n(rst_n), .salt_in(salt_in), .target_in(target_in),
        .cand_valid(cand_valid), .cand_pass(cand_pass), .cand_ready(cand_ready),
        .flush(flush), .eng_super_round(eng_super_round), .eng_des_round(eng_des_round),
        .eng_out(eng_out), .eng_pass(eng_pass), .eng_salt(eng_salt),
        .hit_valid(hit_valid), .hit_pass(hit_pass), .hit_slot(hit_slot),
        .batch_done(batch_done), .batch_hits(batch_hits), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [3:0]  slot;
        logic [63:0] pass;
        logic [4:0]  hits;
        logic [15:0] salt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc;
    int          lap;
    int          last_c;
    logic [63:0] key_reg [16];
    logic [63:0] cur [16];

    function automatic logic [87:0] hfn(input logic [63:0] k, input logic [15:0] s);
        return {s ^ 16'h5a5a, 8'hc3, k ^ 64'h0123_4567_89ab_cdef};
    endfunction

    // Engine model: free-running lap counter, reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always_comb begin
        lap             = cyc % 400;
        eng_super_round = 5'(lap / 16);
        eng_des_round   = 4'(lap % 16);
    end

    // Keys entering at super round 0 produce the hash presented at the next lap's 0/s.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) key_reg[i] <= 64'd0;
        end else if (eng_super_round == 5'd0) begin
            key_reg[eng_des_round] <= eng_pass;
        end
    end

    always_comb eng_out = hfn(key_reg[eng_des_round], eng_salt);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a hit or done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hit_valid) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    total++; bad++;
                    $display("FAIL unexpected_hit: actual slot=%0d cyc=%0d required=none", hit_slot, cyc);
                end else begin
                    e = sb.pop_front();
                    check("hit_slot", 128'(hit_slot), 128'(e.slot));
                    check("hit_pass", 128'(hit_pass), 128'(e.pass));
                    check("hit_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
            if (batch_done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: actual hits=%0d cyc=%0d required=none", batch_hits, cyc);
                end else begin
                    e = sb.pop_front();
                    check("batch_hits", 128'(batch_hits), 128'(e.hits));
                    check("done_cycle", 128'(cyc), 128'(e.cyc));
                    check("done_salt", 128'(eng_salt), 128'(e.salt));
                    check("done_busy", 128'(busy), 128'(0));
                end
            end
        end
    end

    function automatic int launch_after(input int c);
        int t = c + 1;
        while (t % 400 != 399) t++;
        return t + 1;
    endfunction

    task automatic push_batch(input int c, input logic [15:0] mask, input logic [15:0] salt,
                              output int t_launch);
        exp_t e;
        int   k = 0;
        t_launch = launch_after(c);
        for (int s = 0; s < 16; s++) begin
            if (mask[s]) begin
                e.is_done = 1'b0; e.slot = 4'(s); e.pass = cur[s]; e.hits = 5'd0;
                e.salt = salt; e.cyc = t_launch + 401 + s;
                sb.push_back(e);
                k++;
            end
        end
        e.is_done = 1'b1; e.slot = 4'd0; e.pass = 64'd0; e.hits = 5'(k);
        e.salt = salt; e.cyc = t_launch + 416;
        sb.push_back(e);
    endtask

    task automatic send(input logic [63:0] p);
        cand_valid = 1'b1;
        cand_pass  = p;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cand_ready) begin
                last_c = cyc;
                @(posedge clk); #1;
                cand_valid = 1'b0;
                return;
            end
        end
        total++; bad++;
        $display("FAIL send_timeout: actual=no_ready required=ready");
        cand_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        last_c = cyc;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL idle_timeout: actual pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 3000 && cyc < target; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_hit_valid"}, 128'(hit_valid), 128'(0));
        check({tag, "_batch_done"}, 128'(batch_done), 128'(0));
        check({tag, "_batch_hits"}, 128'(batch_hits), 128'(0));
        check({tag, "_eng_pass"}, 128'(eng_pass), 128'(0));
        check({tag, "_eng_salt"}, 128'(eng_salt), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [63:0] x;
        cand_valid = 1'b0; cand_pass = 64'd0; flush = 1'b0;
        salt_in = "ab"; target_in = 88'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cand_ready", 128'(cand_ready), 128'(0));
        check_quiet("rst");
        check("rst_hit_pass", 128'(hit_pass), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_fill_ready", 128'(cand_ready), 128'(1));
        @(posedge clk); #1;

        // Full batch, single hit in slot 5.
        for (int i = 0; i < 16; i++) cur[i] = 64'h7077_0000_0000_0000 | 64'(i);
        cur[5] = {"test", 32'h0};
        salt_in = "ab"; target_in = hfn(cur[5], "ab");
        for (int i = 0; i < 16; i++) send(cur[i]);
        push_batch(last_c, 16'h0020, "ab", t);
        wait_idle();

        // Partial batch: empty slots hash to the target but must not hit.
        for (int i = 0; i < 3; i++) cur[i] = 64'h5061_7274_0000_0000 | 64'(i);
        salt_in = "xy"; target_in = hfn(64'd0, "xy");
        for (int i = 0; i < 3; i++) send(cur[i]);
        do_flush();
        push_batch(last_c, 16'h0000, "xy", t);
        wait_idle();

        // Flush with an empty batch.
        do_flush();
        repeat (20) @(negedge clk);
        check("empty_flush_busy", 128'(busy), 128'(0));
        check("empty_flush_ready", 128'(cand_ready), 128'(1));
        @(posedge clk); #1;

        // Duplicates in slots 0 and 15, plus a flush during RUN.
        x = {"dupe", 32'h2121_0000};
        for (int i = 0; i < 16; i++) cur[i] = 64'hd000_0000_0000_0000 | 64'(i);
        cur[0] = x; cur[15] = x;
        salt_in = "zz"; target_in = hfn(x, "zz");
        for (int i = 0; i < 16; i++) send(cur[i]);
        push_batch(last_c, 16'h8001, "zz", t);
        wait_cyc(t + 100);
        do_flush();
        @(negedge clk);
        check("run_flush_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        wait_idle();

        // Backpressure: 20 back-to-back offers; 17th waits for batch_done.
        x = {"hit3", 32'h0};
        salt_in = "ab"; target_in = hfn(x, "ab");
        for (int i = 0; i < 16; i++) cur[i] = 64'hb100 + 64'(i);
        cur[2] = x;
        for (int i = 0; i < 16; i++) send(cur[i]);
        push_batch(last_c, 16'h0004, "ab", t);
        for (int i = 0; i < 4; i++) cur[i] = 64'hb200 + 64'(i);
        cur[2] = x;
        send(cur[0]);
        check("bp_resume_cycle", 128'(last_c), 128'(t + 416));
        for (int i = 1; i < 4; i++) send(cur[i]);
        do_flush();
        push_batch(last_c, 16'h0004, "ab", t);
        wait_idle();

        // Reset in the middle of RUN aborts the batch silently.
        for (int i = 0; i < 16; i++) cur[i] = 64'hab00 + 64'(i);
        salt_in = "rs"; target_in = hfn(cur[7], "rs");
        for (int i = 0; i < 16; i++) send(cur[i]);
        t = launch_after(last_c);
        wait_cyc(t + 200);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cand_ready", 128'(cand_ready), 128'(0));
        check_quiet("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(cand_ready), 128'(1));
        check("post_rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) cur[i] = 64'hcd00 + 64'(i);
        salt_in = "cd"; target_in = hfn(cur[9], "cd");
        for (int i = 0; i < 16; i++) send(cur[i]);
        push_batch(last_c, 16'h0200, "cd", t);
        wait_idle();
        repeat (5) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crypt_batch_sched.md
Name: crypt_batch_sched

Overview:
- Batch scheduler for the 16-slot pipelined UNIX password-crypt engine (25 super rounds × 16 DES stages, free-running 400-cycle lap).
- Collects up to 16 candidate passwords, then aligns the batch launch to the engine lap boundary.
- Each cycle, drives the engine key input from the slot selected by the engine's stage counter.
- At the end of the lap, compares each slot's 88-bit ASCII hash against a target hash and reports hits.

Parameters:
- NUM_SLOTS, 16, candidate slots per batch; fixed to the engine pipeline depth, and no other value is supported.
- LAST_SUPER, 24, final super_round index of an engine lap.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- salt_in  in  16  two-char ASCII salt; sampled at launch
- target_in  in  88  11-char ASCII target hash; sampled at launch
- cand_valid  in  1  candidate offered
- cand_pass  in  64  8-char ASCII password, first char in bits [63:56]
- cand_ready  out  1  candidate accepted when cand_valid & cand_ready
- flush  in  1  one-cycle pulse: launch a partial batch
- eng_super_round  in  5  engine lap counter, upper field
- eng_des_round  in  4  engine lap counter, lower field (slot index)
- eng_out  in  88  engine ASCII hash output
- eng_pass  out  64  key to engine = slot[eng_des_round] (combinational mux); 0 for an invalid slot
- eng_salt  out  16  latched salt
- hit_valid  out  1  one-cycle pulse: a slot matched the target
- hit_pass  out  64  matching password
- hit_slot  out  4  matching slot index
- batch_done  out  1  one-cycle pulse: batch finished
- batch_hits  out  5  hit count of the finished batch (0..16); held until the next batch_done
- busy  out  1  high in ARM, RUN and DRAIN

Behaviour:
- Reset values: all outputs 0; cand_ready 0 during reset and 1 in the first FILL cycle; slot valid bits cleared; fill count 0; state FILL.
- Engine counter = {eng_super_round, eng_des_round}; it advances 1 per cycle and wraps 24/15 -> 0/0. The engine is reset from the same reset.

State FILL:
- cand_ready = (count < 16).
- Each handshake writes slot[count], sets valid[count], and increments count.
- Go to ARM when count reaches 16, or when flush is seen with count > 0. Flush with count == 0 is ignored.
- Flush coincident with the 16th handshake: that candidate is accepted, and the transition is the same.
- A flush pulse in ARM/RUN/DRAIN is ignored.

State ARM:
- cand_ready = 0.
- On the cycle the counter = 24/15: latch salt_in and target_in, and go to RUN, so that RUN's first cycle sees counter 0/0 (launch cycle T).

State RUN:
- Lasts exactly 400 cycles (T .. T+399).
- eng_pass follows eng_des_round every cycle.
- Slots, valid bits, salt and target are frozen.
- Exit to DRAIN after the cycle with counter 24/15.

State DRAIN (T+400 .. T+415, counter 0/0..0/15):
- The engine output for slot s is final on the cycle the counter = 0/s.
- Compare eng_out == target latch, gated by valid[s].
- Registered result: on a match, hit_valid = 1 one cycle later, with hit_pass = slot[s] and hit_slot = s.
- Keys keep being driven during DRAIN; the engine's next lap is don't-care.

Exit from DRAIN:
- On the cycle after counter 0/15 (T+416), pulse batch_done, update batch_hits, clear valid bits and count, and enter FILL.
- The final hit_valid (slot 15) and batch_done fall in the same cycle.

Other rules:
- No backpressure on hit/done outputs.
- Invalid (unfilled) slots never hit, even if their hash equals the target.
- Reset mid-operation returns to FILL with all slots discarded; no hit_valid or batch_done is produced for the aborted batch.
- Comparison is exact, 88-bit equality.

Test Plan:
- Full batch: 16 passwords with slot 5 = "test\0\0\0\0", salt "ab", target = known crypt("test","ab") -> exactly one hit_valid at T+406 with hit_slot=5 and hit_pass = that password; batch_done at T+416 with batch_hits=1.
- Partial batch: 3 candidates, then flush, target matches none -> launch waits for counter 24/15; batch_done at T+416, batch_hits=0, no hit_valid even though empty slots hash zero keys.
- Backpressure: hold cand_valid=1 for 20 cycles -> exactly 16 accepted; cand_ready stays 0 until batch_done; candidates 17+ are held by the source and accepted in the next batch.
- Flush with count=0, and flush during RUN -> no state change, no batch_done.
- Duplicates: same matching password in slots 0 and 15 -> hit_valid at T+401 and T+416; batch_hits=2.
- Reset asserted at T+200, released later -> all outputs 0 and state FILL; no pulses; a new full batch then completes normally.
